// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package riscv_pipe_pkg;

  // Controller state; WAIT remembers the state it interrupted.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SHADOW = 2'd1,
    ST_WAIT   = 2'd2
  } ctrl_state_t;

  // Winning hazard of the current cycle, in decreasing priority.
  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_FREEZE   = 3'd1,
    HZ_BRANCH   = 3'd2,
    HZ_SHADOW   = 3'd3,
    HZ_LOAD_USE = 3'd4,
    HZ_IMEM     = 3'd5
  } hz_cause_t;

  // RUN-state defaults. Enable order: {pc, if_id, id_ex, ex_mem, mem_wb}.
  localparam logic [4:0] RUN_EN        = 5'b11111;
  localparam logic       RUN_IF_ID_CLR = 1'b0;
  localparam logic       RUN_ID_EX_CLR = 1'b0;
  localparam logic       RUN_PC_SEL    = 1'b0;

endpackage

// File: rtl/pipe_wait_timer.sv
// DMEM wait-state timer: counts consecutive freeze cycles (saturating at
// 255) and raises a sticky timeout once the count has reached MAX_WAIT.
module pipe_wait_timer
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic freeze_i,
  output logic timeout_o
);

  localparam logic [7:0] MAX_CMP = 8'(MAX_WAIT);

  logic [7:0] wt_cnt_q, wt_cnt_d;
  logic       timeout_q, timeout_d;

  // Next count and sticky timeout; the count clears as soon as the freeze ends.
  always_comb begin
    wt_cnt_d  = 8'd0;
    timeout_d = timeout_q | (wt_cnt_q == MAX_CMP);
    if (freeze_i) begin
      if (wt_cnt_q == 8'hFF) begin
        wt_cnt_d = wt_cnt_q;
      end else begin
        wt_cnt_d = wt_cnt_q + 8'd1;
      end
    end else begin
      wt_cnt_d = 8'd0;
    end
  end

  // Timer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_cnt_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      wt_cnt_q  <= wt_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: drives per-stage
// enables/clears for load-use stalls, taken-branch flush with an IMEM
// latency shadow, IMEM wait and DMEM wait freezing with a timeout watchdog.
// Optional feature macro: PIPE_PERF_CNT_EN (stall/flush performance counters).
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned MAX_WAIT  = 15,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_MemRead,
  input  logic              ex_branch_taken,
  input  logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_clr,
  output logic              id_ex_clr,
  output logic              pc_sel_branch,
  output logic              dmem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] SH_LOAD = 2'(FLUSH_CYC);

  ctrl_state_t state_q, state_d;
  ctrl_state_t ret_q, ret_d;
  ctrl_state_t eff_state_s;
  logic [1:0]  sh_cnt_q, sh_cnt_d;
  hz_cause_t   cause_s;
  logic        freeze_s;
  logic        load_use_s;
  logic        shadow_act_s;

  // While frozen the controller behaves as the interrupted state once DMEM completes.
  assign eff_state_s  = (state_q == ST_WAIT) ? ret_q : state_q;
  assign freeze_s     = dmem_req && !dmem_ready;
  assign shadow_act_s = (eff_state_s == ST_SHADOW) && (sh_cnt_q != 2'd0);
  // x0 is hard-wired zero, so a load to it never creates a dependency.
  assign load_use_s   = ex_MemRead && (ex_rd != '0) &&
                        (((id_rs1 == ex_rd) && id_rs1_used) ||
                         ((id_rs2 == ex_rd) && id_rs2_used));

  // Priority encoder: the first matching hazard owns the cycle.
  always_comb begin
    cause_s = HZ_NONE;
    if (freeze_s) begin
      cause_s = HZ_FREEZE;
    end else if (ex_branch_taken) begin
      cause_s = HZ_BRANCH;
    end else if (shadow_act_s) begin
      cause_s = HZ_SHADOW;
    end else if (load_use_s) begin
      cause_s = HZ_LOAD_USE;
    end else if (!imem_ready) begin
      cause_s = HZ_IMEM;
    end else begin
      cause_s = HZ_NONE;
    end
  end

  // Output decode from the winning hazard; reset forces bubbles and holds everything.
  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = RUN_EN;
    if_id_clr     = RUN_IF_ID_CLR;
    id_ex_clr     = RUN_ID_EX_CLR;
    pc_sel_branch = RUN_PC_SEL;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end else begin
      case (cause_s)
        HZ_FREEZE: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
        end
        HZ_BRANCH: begin
          pc_sel_branch = 1'b1;
          if_id_clr     = 1'b1;
          id_ex_clr     = 1'b1;
        end
        HZ_SHADOW: begin
          if_id_clr = 1'b1;
        end
        HZ_LOAD_USE: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_clr = 1'b1;
        end
        HZ_IMEM: begin
          pc_en     = 1'b0;
          if_id_clr = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next state: freeze parks the effective state in ret; leaving WAIT restores it.
  always_comb begin
    state_d  = eff_state_s;
    ret_d    = ret_q;
    sh_cnt_d = sh_cnt_q;
    case (cause_s)
      HZ_FREEZE: begin
        state_d = ST_WAIT;
        ret_d   = eff_state_s;
      end
      HZ_BRANCH: begin
        if (FLUSH_CYC > 0) begin
          state_d  = ST_SHADOW;
          sh_cnt_d = SH_LOAD;
        end else begin
          state_d  = ST_RUN;
          sh_cnt_d = 2'd0;
        end
      end
      HZ_SHADOW: begin
        sh_cnt_d = sh_cnt_q - 2'd1;
        state_d  = (sh_cnt_q == 2'd1) ? ST_RUN : ST_SHADOW;
      end
      default: begin
      end
    endcase
  end

  // Controller state registers; reset aborts WAIT or SHADOW immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      ret_q    <= ST_RUN;
      sh_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      sh_cnt_q <= sh_cnt_d;
    end
  end

  pipe_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .freeze_i  (freeze_s),
    .timeout_o (dmem_timeout)
  );

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_ev_s;
  logic             flush_ev_s;

  assign stall_ev_s = (cause_s == HZ_FREEZE) || (cause_s == HZ_LOAD_USE) ||
                      (cause_s == HZ_IMEM);
  assign flush_ev_s = (cause_s == HZ_BRANCH);

  // Saturating event counters; they stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_ev_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (FLUSH_CYC=1/MAX_WAIT=4
// and FLUSH_CYC=2/MAX_WAIT=15) share stimulus; a cycle-level reference model
// checks both every cycle, plus a vector table and directed sequences.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int FL [2] = '{1, 2};
  localparam int MW [2] = '{4, 15};

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_clr, id_ex_clr, pc_sel_branch}
  localparam logic [7:0] O_RUN = 8'b11111_000;
  localparam logic [7:0] O_BR  = 8'b11111_111;
  localparam logic [7:0] O_SH  = 8'b11111_100;
  localparam logic [7:0] O_LU  = 8'b00111_010;
  localparam logic [7:0] O_IM  = 8'b01111_100;
  localparam logic [7:0] O_FZ  = 8'b00000_000;
  localparam logic [7:0] O_RST = 8'b00000_110;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       imr;
    logic       dreq;
    logic       drdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_MemRead, ex_branch_taken;
  logic       imem_ready, dmem_req, dmem_ready;

  logic [1:0]  pc_en_a, if_id_en_a, id_ex_en_a, ex_mem_en_a, mem_wb_en_a;
  logic [1:0]  if_id_clr_a, id_ex_clr_a, pc_sel_a, timeout_a;
  logic [31:0] stall_a [2];
  logic [31:0] flush_a [2];

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_CYC(1), .MAX_WAIT(4), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en_a[0]), .if_id_en(if_id_en_a[0]), .id_ex_en(id_ex_en_a[0]),
    .ex_mem_en(ex_mem_en_a[0]), .mem_wb_en(mem_wb_en_a[0]),
    .if_id_clr(if_id_clr_a[0]), .id_ex_clr(id_ex_clr_a[0]),
    .pc_sel_branch(pc_sel_a[0]), .dmem_timeout(timeout_a[0]),
    .stall_cnt(stall_a[0]), .flush_cnt(flush_a[0]));

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_CYC(2), .MAX_WAIT(15), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en_a[1]), .if_id_en(if_id_en_a[1]), .id_ex_en(id_ex_en_a[1]),
    .ex_mem_en(ex_mem_en_a[1]), .mem_wb_en(mem_wb_en_a[1]),
    .if_id_clr(if_id_clr_a[1]), .id_ex_clr(id_ex_clr_a[1]),
    .pc_sel_branch(pc_sel_a[1]), .dmem_timeout(timeout_a[1]),
    .stall_cnt(stall_a[1]), .flush_cnt(flush_a[1]));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining shadow cycles, consecutive wait length, flags, counts.
  int     m_shadow [2];
  int     m_wlen   [2];
  bit     m_to     [2];
  longint m_stall  [2];
  longint m_flush  [2];

  function automatic in_t mkin(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic rs1u, input logic rs2u,
                               input logic [4:0] rd, input logic mr, input logic br,
                               input logic imr, input logic dreq, input logic drdy);
    in_t v;
    v.rst = 1'b0; v.rs1 = rs1; v.rs2 = rs2; v.rs1u = rs1u; v.rs2u = rs2u;
    v.rd = rd; v.mr = mr; v.br = br; v.imr = imr; v.dreq = dreq; v.drdy = drdy;
    return v;
  endfunction

  function automatic logic [7:0] dut_out(input int k);
    return {pc_en_a[k], if_id_en_a[k], id_ex_en_a[k], ex_mem_en_a[k], mem_wb_en_a[k],
            if_id_clr_a[k], id_ex_clr_a[k], pc_sel_a[k]};
  endfunction

  function automatic bit is_lu(input in_t v);
    return v.mr && (v.rd != 5'd0) &&
           ((v.rs1 == v.rd && v.rs1u) || (v.rs2 == v.rd && v.rs2u));
  endfunction

  function automatic logic [7:0] model_out(input int k, input in_t v);
    if (v.rst)                 return O_RST;
    if (v.dreq && !v.drdy)     return O_FZ;
    if (v.br)                  return O_BR;
    if (m_shadow[k] > 0)       return O_SH;
    if (is_lu(v))              return O_LU;
    if (!v.imr)                return O_IM;
    return O_RUN;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s u%0d @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic model_step(input in_t v);
    for (int k = 0; k < 2; k++) begin
      chk("model_out", k, 32'(dut_out(k)), 32'(model_out(k, v)));
      chk("model_timeout", k, 32'(timeout_a[k]), 32'(m_to[k]));
      chk("model_stall", k, stall_a[k], PERF ? 32'(m_stall[k]) : 32'd0);
      chk("model_flush", k, flush_a[k], PERF ? 32'(m_flush[k]) : 32'd0);
      if (v.rst) begin
        m_shadow[k] = 0; m_wlen[k] = 0; m_to[k] = 1'b0;
        m_stall[k] = 0;  m_flush[k] = 0;
      end else begin
        if (m_wlen[k] == MW[k]) m_to[k] = 1'b1;
        if (v.dreq && !v.drdy) begin
          if (m_wlen[k] < 255) m_wlen[k]++;
          if (m_stall[k] < 64'hFFFF_FFFF) m_stall[k]++;
        end else begin
          m_wlen[k] = 0;
          if (v.br) begin
            m_shadow[k] = FL[k];
            if (m_flush[k] < 64'hFFFF_FFFF) m_flush[k]++;
          end else if (m_shadow[k] > 0) begin
            m_shadow[k]--;
          end else if (is_lu(v) || !v.imr) begin
            if (m_stall[k] < 64'hFFFF_FFFF) m_stall[k]++;
          end
        end
      end
    end
  endtask

  // Apply one cycle's inputs, then run the model check while outputs are settled.
  task automatic drive(input in_t v);
    rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.rs1u;
    id_rs2_used = v.rs2u; ex_rd = v.rd; ex_MemRead = v.mr; ex_branch_taken = v.br;
    imem_ready = v.imr; dmem_req = v.dreq; dmem_ready = v.drdy;
    #2;
    model_step(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string name, input int k, input logic [7:0] exp);
    chk(name, k, 32'(dut_out(k)), 32'(exp));
  endtask

  vec_t tbl [15];
  in_t  idle_v, rst_v, br_v, fz_v, rdy_v, fzbr_v, rdybr_v, rv;
  int   hold;

  initial begin
    idle_v  = mkin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_v   = idle_v; rst_v.rst = 1'b1;
    br_v    = idle_v; br_v.br = 1'b1;
    fz_v    = idle_v; fz_v.dreq = 1'b1;
    rdy_v   = fz_v;   rdy_v.drdy = 1'b1;
    fzbr_v  = fz_v;   fzbr_v.br = 1'b1;
    rdybr_v = rdy_v;  rdybr_v.br = 1'b1;

    tbl[0]  = '{"idle",        idle_v, O_RUN};
    tbl[1]  = '{"lu_rs2",      mkin(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), O_LU};
    tbl[2]  = '{"lu_rs1",      mkin(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), O_LU};
    tbl[3]  = '{"lu_unused",   mkin(5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), O_RUN};
    tbl[4]  = '{"lu_x0",       mkin(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), O_RUN};
    tbl[5]  = '{"no_load",     mkin(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), O_RUN};
    tbl[6]  = '{"branch",      br_v, O_BR};
    tbl[7]  = '{"br_over_lu",  mkin(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), O_BR};
    tbl[8]  = '{"imem_wait",   mkin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_IM};
    tbl[9]  = '{"lu_over_im",  mkin(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_LU};
    tbl[10] = '{"freeze",      fz_v, O_FZ};
    tbl[11] = '{"fz_over_br",  fzbr_v, O_FZ};
    tbl[12] = '{"dmem_done",   rdy_v, O_RUN};
    tbl[13] = '{"br_over_im",  mkin(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), O_BR};
    tbl[14] = '{"lu_other_rd", mkin(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), O_RUN};

    // Bring both instances out of an unknown state before the model starts.
    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_MemRead = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1;
    dmem_req = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;

    // Vector table: each entry applied for one cycle from a freshly reset RUN state.
    for (int i = 0; i < 15; i++) begin
      drive(rst_v); ex("reset_out", 0, O_RST); ex("reset_out", 1, O_RST); next_cycle();
      drive(tbl[i].i); ex(tbl[i].name, 0, tbl[i].exp); ex(tbl[i].name, 1, tbl[i].exp);
      next_cycle();
    end

    // Load-use lasts exactly one cycle.
    drive(rst_v); next_cycle();
    drive(tbl[1].i); ex("lu_stall", 0, O_LU); next_cycle();
    drive(idle_v); ex("lu_after", 0, O_RUN); next_cycle();

    // Branch followed by its IMEM shadow (1 cycle on u0, 2 on u1).
    drive(rst_v); next_cycle();
    drive(br_v);   ex("br_cycle", 0, O_BR); ex("br_cycle", 1, O_BR); next_cycle();
    drive(idle_v); ex("shadow1", 0, O_SH);  ex("shadow1", 1, O_SH);  next_cycle();
    drive(idle_v); ex("shadow_end", 0, O_RUN); ex("shadow2", 1, O_SH); next_cycle();
    drive(idle_v); ex("shadow_end", 1, O_RUN);
    chk("flush_cnt", 0, flush_a[0], PERF ? 32'd1 : 32'd0); next_cycle();

    // DMEM wait: short wait leaves timeout clear, long wait sets it stickily.
    drive(rst_v); next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(fz_v); ex("freeze3", 0, O_FZ); chk("timeout_short", 0, 32'(timeout_a[0]), 32'd0);
      next_cycle();
    end
    drive(rdy_v);  ex("wait_done", 0, O_RUN); next_cycle();
    drive(idle_v); chk("timeout_short", 0, 32'(timeout_a[0]), 32'd0); next_cycle();
    for (int i = 0; i < 6; i++) begin
      drive(fz_v); ex("freeze6", 0, O_FZ); next_cycle();
    end
    drive(rdy_v);  ex("wait_done6", 0, O_RUN); next_cycle();
    drive(idle_v);
    chk("timeout_set", 0, 32'(timeout_a[0]), 32'd1);
    chk("timeout_u1", 1, 32'(timeout_a[1]), 32'd0);
    chk("stall_cnt", 0, stall_a[0], PERF ? 32'd9 : 32'd0);
    next_cycle();
    drive(idle_v); chk("timeout_sticky", 0, 32'(timeout_a[0]), 32'd1); next_cycle();

    // Reset while u1 is mid-shadow (sh_cnt=2) and u0 has a sticky timeout.
    drive(br_v); next_cycle();
    drive(rst_v);  ex("rst_mid", 0, O_RST); ex("rst_mid", 1, O_RST); next_cycle();
    drive(idle_v); ex("after_rst", 0, O_RUN); ex("after_rst", 1, O_RUN);
    chk("after_rst_timeout", 0, 32'(timeout_a[0]), 32'd0);
    chk("after_rst_stall", 0, stall_a[0], 32'd0);
    chk("after_rst_flush", 1, flush_a[1], 32'd0);
    next_cycle();

    // Branch held during a freeze takes effect when DMEM completes.
    drive(rst_v); next_cycle();
    drive(fzbr_v);  ex("fz_br_hold", 0, O_FZ); next_cycle();
    drive(fzbr_v);  ex("fz_br_hold", 0, O_FZ); next_cycle();
    drive(rdybr_v); ex("fz_br_release", 0, O_BR); next_cycle();
    drive(idle_v);  ex("fz_br_shadow", 0, O_SH); next_cycle();
    drive(idle_v);  ex("fz_br_run", 0, O_RUN); next_cycle();

    // Randomized traffic against the reference model, with occasional long DMEM waits.
    hold = 0;
    for (int n = 0; n < 2000; n++) begin
      rv.rst  = ($urandom_range(0, 99) == 0);
      rv.rs1  = 5'($urandom_range(0, 3));
      rv.rs2  = 5'($urandom_range(0, 3));
      rv.rs1u = 1'($urandom_range(0, 1));
      rv.rs2u = 1'($urandom_range(0, 1));
      rv.rd   = 5'($urandom_range(0, 3));
      rv.mr   = 1'($urandom_range(0, 1));
      rv.br   = ($urandom_range(0, 5) == 0);
      rv.imr  = ($urandom_range(0, 4) != 0);
      rv.dreq = ($urandom_range(0, 9) < 3);
      rv.drdy = 1'($urandom_range(0, 1));
      if (hold > 0) begin
        rv.dreq = 1'b1; rv.drdy = 1'b0; hold--;
      end else if ($urandom_range(0, 49) == 0) begin
        hold = $urandom_range(5, 20);
      end
      drive(rv);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RV32 core. It replaces the fixed NOP-injection stall logic with per-stage enable and clear control. It also handles load-use stalls, taken-branch flush with a configurable shadow for synchronous IMEM latency, and IMEM/DMEM wait-state freezing with a DMEM timeout watchdog. It sits beside the pipeline registers and drives the enable/clear inputs of Reg_PC, Reg_IF_ID, Reg_ID_EX, Reg_EX_MEM and Reg_MEM_WB.

## Interface
Parameters:
- REG_AW, 5: register address width (4 for RV32E).
- FLUSH_CYC, 1: extra cycles IF/ID is cleared after a taken branch (synchronous IMEM latency); range 0..3.
- MAX_WAIT, 15: DMEM wait cycles before `dmem_timeout` sets; range 1..255.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the source is actually read.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_MemRead  in  1  the instruction in EX is a load.
- ex_branch_taken  in  1  taken branch or jump resolved in EX.
- imem_ready  in  1  IMEM data valid this cycle.
- dmem_req  in  1  the MEM stage is accessing DMEM.
- dmem_ready  in  1  DMEM access completes this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register load enables.
- if_id_clr, id_ex_clr  out  1  load a bubble into IF/ID and ID/EX respectively.
- pc_sel_branch  out  1  the PC loads the branch target.
- dmem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters (see Configuration).

## Operation
- State register `ctrl_state` takes values RUN, SHADOW and WAIT. A shadow counter `sh_cnt` (2 bits) and a wait counter `wt_cnt` (8 bits) accompany it.
- Each cycle evaluates the conditions below in priority order. The first condition that matches sets the outputs. Any output not named takes its default: enables 1, clears 0, pc_sel_branch 0.
  1. **Freeze** (`dmem_req && !dmem_ready`):
     - All enables 0 and all clears 0; the pipeline holds.
     - State moves to WAIT and `wt_cnt` increments, saturating at 255.
     - When `wt_cnt` reaches MAX_WAIT, `dmem_timeout` sets on the next edge and stays set until rst.
     - `sh_cnt` holds.
  2. **Branch** (`ex_branch_taken`):
     - pc_sel_branch=1, if_id_clr=1, id_ex_clr=1.
     - If FLUSH_CYC>0: state moves to SHADOW and `sh_cnt` loads FLUSH_CYC.
     - A branch asserted while in SHADOW reloads `sh_cnt`.
  3. **Shadow** (state SHADOW and `sh_cnt`≠0):
     - if_id_clr=1.
     - `sh_cnt` decrements; state returns to RUN when it reaches 0.
  4. **Load-use** (`ex_MemRead && ex_rd!=0` and a match on (`id_rs1==ex_rd && id_rs1_used`) or (`id_rs2==ex_rd && id_rs2_used`)):
     - pc_en=0, if_id_en=0, id_ex_clr=1.
     - Lasts exactly one cycle, because the load advances to MEM.
  5. **IMEM wait** (`!imem_ready`): pc_en=0, if_id_clr=1.
  6. **RUN**: defaults.
- Leaving WAIT (dmem_ready=1) clears `wt_cnt` and restores the state held before the freeze (RUN or SHADOW).
- Register x0 never causes a load-use stall.

## Timing
- All outputs are combinational from the inputs and the registered state, with zero-cycle latency. The state is registered.
- Load-use costs 1 bubble. A taken branch costs 2 + FLUSH_CYC bubbles.
- A DMEM wait of N cycles freezes the pipeline for exactly N cycles. No instruction is lost or duplicated.
- Reset (sampled on the edge while rst=1):
  - During rst: all enables 0, if_id_clr=1, id_ex_clr=1, pc_sel_branch=0.
  - State returns to RUN; sh_cnt, wt_cnt, dmem_timeout, stall_cnt and flush_cnt all reset to 0.
  - Reset asserted in WAIT or SHADOW aborts that state immediately.
- Simultaneous branch and load-use: the branch wins and no stall occurs.
- Simultaneous freeze and branch: the branch is held and takes effect in the cycle dmem_ready=1.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cnt` increments in every freeze, load-use or IMEM-wait cycle.
  - `flush_cnt` increments on every branch cycle.
  - Both saturate at all-ones and never wrap.
- Not defined: both counters are constant 0 and no counter flops exist.

## Structure
- `riscv_pipe_pkg` holds:
  - the `ctrl_state_t` enum (RUN, SHADOW, WAIT);
  - the `hz_cause_t` enum (NONE, FREEZE, BRANCH, SHADOW, LOAD_USE, IMEM);
  - the RUN-state enable default constants.
- One sub-module, `pipe_wait_timer`, holds `wt_cnt`, the saturation logic, the MAX_WAIT compare and the sticky `dmem_timeout`.
- The priority encoder stays in the top of the block.

## Test plan
- **Load-use:** ex_MemRead=1, ex_rd=5, id_rs2=5, id_rs2_used=1 → 1 cycle with pc_en=0, if_id_en=0, id_ex_clr=1; RUN the next cycle. Repeat with ex_rd=0 → no stall.
- **Branch shadow:** FLUSH_CYC=1, ex_branch_taken pulse → branch cycle with pc_sel_branch=1, if_id_clr=1, id_ex_clr=1; next cycle if_id_clr=1 only; then RUN. flush_cnt=1 with macro, 0 without.
- **DMEM wait:** dmem_req=1, dmem_ready=0 for 3 cycles → all enables 0 for 3 cycles; dmem_timeout stays 0. Then with MAX_WAIT=4 hold for 6 cycles → dmem_timeout=1, still 1 after dmem_ready=1.
- **Freeze over branch:** freeze plus ex_branch_taken together → pc_sel_branch=0 during the freeze; pc_sel_branch=1 in the cycle dmem_ready rises.
- **Reset mid-operation:** rst in SHADOW with sh_cnt=2 → the next cycle after rst deasserts is RUN with all enables 1; counters and dmem_timeout are 0.
- **Branch vs load-use:** ex_branch_taken=1 with a load-use match → branch outputs only, pc_en=1.
